// File: rtl/jtdsp16_do_cache_if.sv
// jtdsp16_do_cache_if: decoder/fetch-side bus of the do/redo loop cache
interface jtdsp16_do_cache_if;
  logic        cen;
  logic        do_start;
  logic [10:0] do_data;
  logic        fetch_en;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        up_xcache;
  logic        pc_halt;
  logic        no_int;
  logic        busy;
  logic        err;
  modport master (
    output cen, do_start, do_data, fetch_en, rom_dout,
    input  cache_dout, up_xcache, pc_halt, no_int, busy, err
  );
  modport slave (
    input  cen, do_start, do_data, fetch_en, rom_dout,
    output cache_dout, up_xcache, pc_halt, no_int, busy, err
  );
endinterface

// File: rtl/jtdsp16_do_cache.sv
// jtdsp16_do_cache: captures a do-loop body on its first pass, then replays it from local storage
module jtdsp16_do_cache #(
  parameter int AW = 4,
  parameter int KW = 7
) (
  input logic               clk,
  input logic               rst,
  jtdsp16_do_cache_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, ni_reg_q, ni_reg_d;
  logic [KW-1:0] iter_q, iter_d;
  logic          err_q, err_d, mem_we;
  logic [15:0]   mem [2**AW];
  logic [AW-1:0] ni;
  logic [KW-1:0] k, k_eff;
  logic          last_wr, last_rd, last_iter;
  assign ni        = AW'(bus.do_data[10:7]);
  assign k         = KW'(bus.do_data[6:0]);
  assign k_eff     = (k == '0) ? KW'(1) : k;
  assign last_wr   = wr_addr_q == ni_reg_q - AW'(1);
  assign last_rd   = rd_addr_q == ni_reg_q - AW'(1);
  assign last_iter = iter_q == KW'(1);
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    ni_reg_d  = ni_reg_q;
    iter_d    = iter_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    if (bus.cen) begin
      unique case (state_q)
        IDLE: if (bus.do_start) begin
          if (ni != '0) begin
            ni_reg_d  = ni;
            wr_addr_d = '0;
            iter_d    = k_eff;
            err_d     = err_q | (k == '0);
            state_d   = LOAD;
          end else if (ni_reg_q == '0) begin
            err_d = 1'b1;
          end else begin
            iter_d    = k_eff;
            err_d     = err_q | (k == '0);
            rd_addr_d = '0;
            state_d   = REPLAY;
          end
        end
        LOAD: begin
          err_d = err_q | bus.do_start;
          if (bus.fetch_en) begin
            mem_we    = 1'b1;
            wr_addr_d = last_wr ? '0 : wr_addr_q + AW'(1);
            if (last_wr) begin
              rd_addr_d = '0;
              iter_d    = last_iter ? iter_q : iter_q - KW'(1);
              state_d   = last_iter ? IDLE : REPLAY;
            end
          end
        end
        default: begin
          err_d = err_q | bus.do_start;
          if (bus.fetch_en) begin
            rd_addr_d = last_rd ? '0 : rd_addr_q + AW'(1);
            if (last_rd) begin
              iter_d  = iter_q - KW'(1);
              state_d = last_iter ? IDLE : REPLAY;
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ni_reg_q  <= '0;
      iter_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      ni_reg_q  <= ni_reg_d;
      iter_q    <= iter_d;
      err_q     <= err_d;
    end
  end
  // Storage is not cleared on reset; ni_reg=0 is what marks it empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= bus.rom_dout;
  end
  assign bus.cache_dout = mem[rd_addr_q];
  assign bus.up_xcache  = state_q == REPLAY;
  assign bus.pc_halt    = state_q == REPLAY;
  assign bus.busy       = state_q != IDLE;
  assign bus.no_int     = state_q != IDLE;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// tb_jtdsp16_do_cache: directed loop scenarios plus randomized loops checked against a body-repeat model
module tb_jtdsp16_do_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  jtdsp16_do_cache_if bus();
  jtdsp16_do_cache dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] ni, input logic [6:0] k);
    bus.do_start = 1'b1;
    bus.do_data  = {ni, k};
    bus.fetch_en = 1'b0;
    tick();
    bus.do_start = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.rom_dout = w;
    bus.fetch_en = 1'b1;
    chk("load_up", bus.up_xcache, 1'b0);
    chk("load_noint", bus.no_int, 1'b1);
    tick();
    bus.fetch_en = 1'b0;
  endtask

  task automatic replay_word(input logic [15:0] exp);
    bus.rom_dout = 16'($urandom);
    bus.fetch_en = 1'b1;
    chk("rep_dout", bus.cache_dout, exp);
    chk("rep_up", bus.up_xcache, 1'b1);
    chk("rep_halt", bus.pc_halt, 1'b1);
    tick();
    bus.fetch_en = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_up"}, bus.up_xcache, 1'b0);
    chk({tag, "_halt"}, bus.pc_halt, 1'b0);
    chk({tag, "_noint"}, bus.no_int, 1'b0);
  endtask

  initial begin
    logic [15:0] body [3];
    logic [15:0] rbody [15];
    logic [15:0] vis;
    int n, kk, idx, cyc;
    body[0] = 16'h1111;
    body[1] = 16'h2222;
    body[2] = 16'h3333;
    bus.cen      = 1'b1;
    bus.do_start = 1'b0;
    bus.do_data  = '0;
    bus.fetch_en = 1'b0;
    bus.rom_dout = '0;
    tick();
    rst = 1'b0;
    expect_idle("reset");
    chk("reset_err", bus.err, 1'b0);

    issue(4'd3, 7'd3);
    chk("do_busy", bus.busy, 1'b1);
    chk("do_noint", bus.no_int, 1'b1);
    for (int i = 0; i < 3; i++) load_word(body[i]);
    for (int i = 0; i < 6; i++) replay_word(body[i % 3]);
    expect_idle("do3x3_end");
    chk("do3x3_err", bus.err, 1'b0);

    issue(4'd0, 7'd2);
    for (int i = 0; i < 6; i++) replay_word(body[i % 3]);
    expect_idle("redo_end");

    issue(4'd0, 7'd2);
    replay_word(body[0]);
    for (int i = 0; i < 5; i++) begin
      bus.cen = (i != 2);
      chk("stall_dout", bus.cache_dout, body[1]);
      chk("stall_up", bus.up_xcache, 1'b1);
      tick();
    end
    bus.cen = 1'b1;
    for (int i = 1; i < 6; i++) replay_word(body[i % 3]);
    expect_idle("stall_end");

    issue(4'd0, 7'd1);
    replay_word(body[0]);
    issue(4'd4, 7'd5);
    chk("busy_do_err", bus.err, 1'b1);
    chk("busy_do_up", bus.up_xcache, 1'b1);
    replay_word(body[1]);
    replay_word(body[2]);
    expect_idle("busy_do_end");
    issue(4'd0, 7'd1);
    replay_word(body[0]);
    replay_word(body[1]);
    chk("ni_kept_busy", bus.busy, 1'b1);
    replay_word(body[2]);
    chk("ni_kept_idle", bus.busy, 1'b0);

    issue(4'd0, 7'd2);
    for (int i = 0; i < 4; i++) replay_word(body[i % 3]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle("rst_rep");
    chk("rst_rep_err", bus.err, 1'b0);
    issue(4'd0, 7'd3);
    chk("redo_empty_err", bus.err, 1'b1);
    chk("redo_empty_busy", bus.busy, 1'b0);

    issue(4'd2, 7'd1);
    load_word(16'haaaa);
    load_word(16'hbbbb);
    expect_idle("k1_end");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    issue(4'd1, 7'd0);
    chk("k0_err", bus.err, 1'b1);
    chk("k0_busy", bus.busy, 1'b1);
    load_word(16'h5a5a);
    expect_idle("k0_end");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int l = 0; l < 8; l++) begin
      n  = $urandom_range(1, 15);
      kk = $urandom_range(1, 4);
      for (int i = 0; i < 15; i++) rbody[i] = 16'($urandom);
      issue(4'(n), 7'(kk));
      idx = 0;
      cyc = 0;
      while (idx < n * kk && cyc < 2000) begin
        bus.cen      = $urandom_range(0, 3) != 0;
        bus.fetch_en = $urandom_range(0, 2) != 0;
        bus.rom_dout = (idx < n) ? rbody[idx] : 16'($urandom);
        if (bus.cen && bus.fetch_en) begin
          vis = bus.up_xcache ? bus.cache_dout : bus.rom_dout;
          chk("rnd_word", vis, rbody[idx % n]);
          chk("rnd_up", bus.up_xcache, 32'(idx >= n));
          chk("rnd_busy", bus.busy, 1'b1);
          idx++;
        end
        tick();
        cyc++;
      end
      bus.cen      = 1'b1;
      bus.fetch_en = 1'b0;
      chk("rnd_budget", idx, n * kk);
      expect_idle("rnd_end");
      chk("rnd_err", bus.err, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/jtdsp16_do_cache.md
Name: jtdsp16_do_cache

Overview:
- Instruction cache and loop sequencer for the DSP16 `do K {NI}` and `redo K` instructions.
- Consumes the `do_start` and `do_data` pulse issued by the instruction decoder.
- On the first loop pass it captures the NI instruction words fetched from ROM. It then replays them from internal storage for the remaining passes, holding the program counter meanwhile.
- It supplies `cache_dout` and the `up_xcache` selection back to the decoder and fetch path.

Parameters:
- AW, 4: cache address width; capacity is 2^AW-1 = 15 words (NI field maximum).
- KW, 7: loop count width (K field of `do_data`).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cen  input  1  clock enable; all state updates only when cen=1
- do_start  input  1  one-cen pulse: do/redo decoded
- do_data  input  11  [10:7]=NI (0 means redo), [6:0]=K
- fetch_en  input  1  an instruction word is consumed by the decoder this cen
- rom_dout  input  16  instruction word currently fetched from ROM
- cache_dout  output  16  replayed instruction word, mem[rd_addr], combinational read
- up_xcache  output  1  decoder must take its instruction from cache_dout
- pc_halt  output  1  hold program counter (replay in progress)
- no_int  output  1  block interrupt acceptance while the loop is active
- busy  output  1  state != IDLE
- err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at clk edge, regardless of cen):
  - State goes to IDLE.
  - wr_addr, rd_addr, ni_reg, iter all go to 0.
  - Outputs up_xcache, pc_halt, no_int, busy and err all go to 0.
  - Memory contents are not cleared, but ni_reg=0 marks the cache empty.
  - A reset during LOAD or REPLAY aborts immediately; no further replay occurs.
- States: IDLE, LOAD, REPLAY. All transitions occur on clk edges with cen=1.
- IDLE + do_start, NI!=0:
  - ni_reg<=NI; wr_addr<=0.
  - iter<=K, except that K=0 forces iter<=1 and sets err.
  - Go to LOAD. Set no_int=1 and busy=1.
- IDLE + do_start, NI=0 (redo):
  - If ni_reg=0: set err and stay IDLE.
  - Else: iter<=K (K=0 forces 1 and sets err); rd_addr<=0.
  - Go to REPLAY with up_xcache=1, pc_halt=1, no_int=1.
- LOAD, on each fetch_en:
  - mem[wr_addr]<=rom_dout; wr_addr++.
  - up_xcache=0 and pc_halt=0: the ROM supplies the first pass.
  - When wr_addr==ni_reg-1 is written (last word):
    - If iter==1: go to IDLE.
    - Else: iter<=iter-1; rd_addr<=0; go to REPLAY, with up_xcache and pc_halt asserted from the next cen.
- REPLAY, on each fetch_en:
  - rd_addr++.
  - When rd_addr==ni_reg-1: rd_addr<=0 and iter<=iter-1.
  - If iter was 1 at that point: go to IDLE, deasserting up_xcache, pc_halt and no_int on the same edge. The next fetch comes from ROM at the held PC (the word after the loop body).
- Without fetch_en (cen=1, fetch_en=0): no state, address or counter changes. This covers decoder stalls such as double-word cycles.
- do_start while busy: ignored, err set. The loop continues unaffected.
- Total body executions equal K (K=1 means LOAD only, no REPLAY).
- cache_dout is undefined-but-stable outside REPLAY, and is driven as mem[rd_addr] at all times.
- Counters: wr_addr and rd_addr are AW bits and never exceed ni_reg-1; iter is KW bits and never underflows.
- err clears only on rst.

Test Plan:
- do NI=3, K=3; words 0x1111, 0x2222, 0x3333 fetched with fetch_en every cen:
  - LOAD captures the three words.
  - The next 6 fetches give cache_dout 1111, 2222, 3333, 1111, 2222, 3333 with up_xcache=1 and pc_halt=1.
  - Both then drop to 0 on the edge consuming the last 3333.
- do NI=2, K=1:
  - Two ROM words are captured and the block returns to IDLE.
  - up_xcache never asserts; no_int is high only for the 2 LOAD fetches.
- redo K=2 after the first test:
  - 6 replayed words 1111, 2222, 3333, 1111, 2222, 3333; then IDLE.
  - redo issued right after reset instead: err=1 and the block stays IDLE.
- fetch_en held low for 5 cens mid-REPLAY (rd_addr=1):
  - cache_dout stays 2222 and iter is unchanged.
  - Sequence resumes correctly afterwards.
- do_start (NI=4, K=5) issued during REPLAY:
  - err=1; the current loop completes with its original count.
  - ni_reg stays 3.
- rst asserted during REPLAY (second pass):
  - Next cycle: busy=0, up_xcache=0, pc_halt=0, err=0.
  - A subsequent redo sets err (cache marked empty).
